// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input VC round-robin, then per-output
// input-port round-robin, with per-downstream-VC credit counters masking requests.
module switch_allocator #(
  parameter int VC_TOTAL    = 10,
  parameter int PORT_NUM    = 5,
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8,
  localparam int VC_SIZE    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int PORT_SIZE  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [VC_TOTAL-1:0]                  request_i,
  input  logic [VC_TOTAL-1:0][PORT_SIZE-1:0]   out_port_i,
  input  logic [VC_TOTAL-1:0][VC_SIZE-1:0]     downstream_vc_i,
  input  logic [VC_TOTAL-1:0]                  credit_i,
  output logic [VC_TOTAL-1:0]                  grant_o,
  output logic [PORT_NUM-1:0][VC_SIZE-1:0]     input_vc_sel_o,
  output logic [PORT_NUM-1:0][PORT_SIZE-1:0]   xb_sel_o,
  output logic [PORT_NUM-1:0]                  valid_flit_o
);
  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam int DW = (VC_TOTAL > 1) ? $clog2(VC_TOTAL) : 1;

  logic [CW-1:0]        credit_reg   [VC_TOTAL];
  logic [CW-1:0]        credit_next  [VC_TOTAL];
  logic [VC_SIZE-1:0]   in_ptr_reg   [PORT_NUM];
  logic [VC_SIZE-1:0]   in_ptr_next  [PORT_NUM];
  logic [PORT_SIZE-1:0] out_ptr_reg  [PORT_NUM];
  logic [PORT_SIZE-1:0] out_ptr_next [PORT_NUM];

  logic [DW-1:0]        target_d [VC_TOTAL];
  logic [VC_TOTAL-1:0]  eligible;
  logic [PORT_NUM-1:0]  s1_valid;
  logic [VC_SIZE-1:0]   s1_vc   [PORT_NUM];
  logic [PORT_SIZE-1:0] s1_port [PORT_NUM];
  logic [PORT_NUM-1:0]  s2_valid;
  logic [PORT_SIZE-1:0] s2_in   [PORT_NUM];
  logic [PORT_NUM-1:0]  in_granted;
  logic [VC_TOTAL-1:0]  grant_c;
  logic [VC_TOTAL-1:0]  consume;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   vc_sel_c;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] xb_sel_c;

  // A request is only eligible if its target downstream VC has buffer space left.
  generate
    for (genvar gi = 0; gi < VC_TOTAL; gi++) begin : g_elig
      assign target_d[gi] = DW'(int'(out_port_i[gi]) * VC_NUM + int'(downstream_vc_i[gi]));
      assign eligible[gi] = request_i[gi]
                          && (int'(out_port_i[gi]) < PORT_NUM)
                          && (int'(downstream_vc_i[gi]) < VC_NUM)
                          && (credit_reg[target_d[gi]] != '0);
    end
  endgenerate

  always_comb begin
    int vc;
    vc = 0;
    for (int i = 0; i < PORT_NUM; i++) begin
      s1_valid[i] = 1'b0;
      s1_vc[i]    = '0;
      for (int k = 0; k < VC_NUM; k++) begin
        vc = (int'(in_ptr_reg[i]) + k) % VC_NUM;
        if (!s1_valid[i] && eligible[i*VC_NUM + vc]) begin
          s1_valid[i] = 1'b1;
          s1_vc[i]    = VC_SIZE'(vc);
        end
      end
      s1_port[i] = out_port_i[i*VC_NUM + int'(s1_vc[i])];
    end
  end

  always_comb begin
    int in_idx;
    int v;
    in_idx     = 0;
    v          = 0;
    s2_valid   = '0;
    in_granted = '0;
    grant_c    = '0;
    consume    = '0;
    vc_sel_c   = '0;
    xb_sel_c   = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      s2_in[p] = '0;
      for (int k = 0; k < PORT_NUM; k++) begin
        in_idx = (int'(out_ptr_reg[p]) + k) % PORT_NUM;
        if (!s2_valid[p] && s1_valid[in_idx] && (int'(s1_port[in_idx]) == p)) begin
          s2_valid[p] = 1'b1;
          s2_in[p]    = PORT_SIZE'(in_idx);
        end
      end
      if (s2_valid[p]) begin
        in_idx                = int'(s2_in[p]);
        v                     = in_idx * VC_NUM + int'(s1_vc[in_idx]);
        grant_c[v]            = 1'b1;
        consume[target_d[v]]  = 1'b1;
        in_granted[in_idx]    = 1'b1;
        vc_sel_c[in_idx]      = s1_vc[in_idx];
        xb_sel_c[p]           = s2_in[p];
      end
    end
  end

  assign grant_o        = rst ? '0 : grant_c;
  assign input_vc_sel_o = rst ? '0 : vc_sel_c;
  assign xb_sel_o       = rst ? '0 : xb_sel_c;
  assign valid_flit_o   = rst ? '0 : s2_valid;

  // A grant and a returned credit on the same VC cancel; a full counter ignores credits.
  generate
    for (genvar gi = 0; gi < VC_TOTAL; gi++) begin : g_credit
      assign credit_next[gi] =
          (consume[gi] && !credit_i[gi]) ? credit_reg[gi] - CW'(1) :
          (!consume[gi] && credit_i[gi] && (credit_reg[gi] != CW'(BUFFER_SIZE)))
                                         ? credit_reg[gi] + CW'(1) : credit_reg[gi];
    end
    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_ptr
      assign out_ptr_next[gi] = s2_valid[gi] ?
          PORT_SIZE'((int'(s2_in[gi]) + 1) % PORT_NUM) : out_ptr_reg[gi];
      assign in_ptr_next[gi]  = in_granted[gi] ?
          VC_SIZE'((int'(s1_vc[gi]) + 1) % VC_NUM) : in_ptr_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < VC_TOTAL; d++) credit_reg[d] <= CW'(BUFFER_SIZE);
      for (int p = 0; p < PORT_NUM; p++) begin
        in_ptr_reg[p]  <= '0;
        out_ptr_reg[p] <= '0;
      end
    end else begin
      for (int d = 0; d < VC_TOTAL; d++) credit_reg[d] <= credit_next[d];
      for (int p = 0; p < PORT_NUM; p++) begin
        in_ptr_reg[p]  <= in_ptr_next[p];
        out_ptr_reg[p] <= out_ptr_next[p];
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios plus random traffic
// against a cycle-level reference model of the two-stage round-robin allocator.
module tb_switch_allocator;
  localparam int VC_TOTAL = 10;
  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;
  localparam int BUF      = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [9:0]            request_i;
  logic [9:0][2:0]       out_port_i;
  logic [9:0][0:0]       downstream_vc_i;
  logic [9:0]            credit_i;
  logic [9:0]            grant_o;
  logic [4:0][0:0]       input_vc_sel_o;
  logic [4:0][2:0]       xb_sel_o;
  logic [4:0]            valid_flit_o;

  int checks   = 0;
  int failures = 0;

  // reference model state and expected outputs
  int          m_credit [VC_TOTAL];
  int          m_in_ptr [PORT_NUM];
  int          m_out_ptr[PORT_NUM];
  int          m_w1     [PORT_NUM];
  int          m_w2     [PORT_NUM];
  logic [9:0]  m_dec;
  logic [9:0]  e_grant;
  logic [4:0]  e_vcsel;
  logic [14:0] e_xb;
  logic [4:0]  e_valid;

  switch_allocator #(
    .VC_TOTAL(VC_TOTAL), .PORT_NUM(PORT_NUM), .VC_NUM(VC_NUM), .BUFFER_SIZE(BUF)
  ) dut (
    .clk(clk), .rst(rst), .request_i(request_i), .out_port_i(out_port_i),
    .downstream_vc_i(downstream_vc_i), .credit_i(credit_i), .grant_o(grant_o),
    .input_vc_sel_o(input_vc_sel_o), .xb_sel_o(xb_sel_o), .valid_flit_o(valid_flit_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < VC_TOTAL; d++) m_credit[d] = BUF;
    for (int p = 0; p < PORT_NUM; p++) begin
      m_in_ptr[p]  = 0;
      m_out_ptr[p] = 0;
    end
  endfunction

  function automatic int dest(input int v);
    return int'(out_port_i[v]) * VC_NUM + int'(downstream_vc_i[v]);
  endfunction

  function automatic void model_eval();
    e_grant = '0; e_vcsel = '0; e_xb = '0; e_valid = '0; m_dec = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      m_w1[i] = -1;
      for (int k = 0; k < VC_NUM; k++) begin
        int vc, v;
        vc = (m_in_ptr[i] + k) % VC_NUM;
        v  = i * VC_NUM + vc;
        if (m_w1[i] < 0 && request_i[v] && m_credit[dest(v)] > 0) m_w1[i] = vc;
      end
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      m_w2[p] = -1;
      for (int k = 0; k < PORT_NUM; k++) begin
        int i;
        i = (m_out_ptr[p] + k) % PORT_NUM;
        if (m_w2[p] < 0 && m_w1[i] >= 0 && int'(out_port_i[i*VC_NUM + m_w1[i]]) == p) m_w2[p] = i;
      end
      if (m_w2[p] >= 0) begin
        int i, v;
        i = m_w2[p];
        v = i * VC_NUM + m_w1[i];
        e_grant[v]     = 1'b1;
        m_dec[dest(v)] = 1'b1;
        e_vcsel[i]     = 1'(m_w1[i]);
        e_xb[p*3 +: 3] = 3'(i);
        e_valid[p]     = 1'b1;
      end
    end
    if (rst) begin
      e_grant = '0; e_vcsel = '0; e_xb = '0; e_valid = '0;
    end
  endfunction

  function automatic void model_clock();
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < VC_TOTAL; d++) begin
      if (m_dec[d] && !credit_i[d]) m_credit[d]--;
      else if (!m_dec[d] && credit_i[d] && m_credit[d] < BUF) m_credit[d]++;
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      if (m_w2[p] >= 0) begin
        m_out_ptr[p]        = (m_w2[p] + 1) % PORT_NUM;
        m_in_ptr[m_w2[p]]   = (m_w1[m_w2[p]] + 1) % VC_NUM;
      end
    end
  endfunction

  // Called one time unit after the inputs change; samples between clock edges.
  task automatic settle_check(input string tag);
    #1;
    model_eval();
    check_eq({tag, "_grant"}, 32'(grant_o), 32'(e_grant));
    check_eq({tag, "_vcsel"}, 32'(input_vc_sel_o), 32'(e_vcsel));
    check_eq({tag, "_xbsel"}, 32'(xb_sel_o), 32'(e_xb));
    check_eq({tag, "_valid"}, 32'(valid_flit_o), 32'(e_valid));
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic random_inputs();
    request_i = 10'($urandom);
    credit_i  = 10'($urandom & $urandom);
    for (int v = 0; v < VC_TOTAL; v++) begin
      out_port_i[v]      = 3'($urandom_range(0, 4));
      downstream_vc_i[v] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] served;
    rst = 1'b1;
    request_i = '1; credit_i = '0; out_port_i = '0; downstream_vc_i = '0;
    model_reset();
    #2;
    settle_check("reset");
    check_eq("reset_grant_zero", 32'(grant_o), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    request_i = '0;

    // single request: VC0 -> output 0, downstream VC 1
    request_i = 10'h001; out_port_i[0] = 3'd0; downstream_vc_i[0] = 1'b1;
    settle_check("single");
    check_eq("single_grant", 32'(grant_o), 32'h001);
    check_eq("single_valid", 32'(valid_flit_o), 32'h01);
    check_eq("single_xb0", 32'(xb_sel_o[0]), 32'h0);
    tick();
    // seven more grants drain the remaining credits of downstream VC 1
    for (int c = 1; c < BUF; c++) begin
      settle_check("drain");
      check_eq("drain_grant", 32'(grant_o[0]), 32'h1);
      tick();
    end
    settle_check("empty");
    check_eq("empty_blocked", 32'(grant_o[0]), 32'h0);
    tick();
    credit_i = 10'h002;
    settle_check("credit_pulse");
    check_eq("credit_pulse_blocked", 32'(grant_o[0]), 32'h0);
    tick();
    credit_i = '0;
    settle_check("refill");
    check_eq("refill_grant", 32'(grant_o[0]), 32'h1);
    tick();
    settle_check("refill_done");
    check_eq("refill_empty", 32'(grant_o[0]), 32'h0);
    tick();

    // everyone to output 1; credits returned to the contended VCs every cycle
    request_i = '1; credit_i = 10'b00_0000_1100;
    for (int v = 0; v < VC_TOTAL; v++) begin
      out_port_i[v] = 3'd1;
      downstream_vc_i[v] = 1'(v % 2);
    end
    served = '0;
    for (int c = 0; c < 10; c++) begin
      settle_check("hotspot");
      check_eq("hotspot_onegrant", 32'($countones(grant_o)), 32'd1);
      check_eq("hotspot_rotate", 32'(xb_sel_o[1]), 32'(c % 5));
      served |= grant_o;
      tick();
    end
    check_eq("hotspot_all_served", 32'(served), 32'h3ff);

    // disjoint outputs: input i targets (i+1)%5
    credit_i = '0;
    for (int v = 0; v < VC_TOTAL; v++) begin
      out_port_i[v] = 3'(((v / 2) + 1) % 5);
      downstream_vc_i[v] = 1'b0;
    end
    settle_check("disjoint");
    check_eq("disjoint_valid", 32'(valid_flit_o), 32'h1f);
    check_eq("disjoint_count", 32'($countones(grant_o)), 32'd5);
    tick();

    // random traffic, then an asynchronous reset mid-cycle
    for (int c = 0; c < 30; c++) begin
      random_inputs();
      settle_check("rand_pre");
      tick();
    end
    request_i = '1;
    rst = 1'b1;
    settle_check("midrst");
    check_eq("midrst_valid_zero", 32'(valid_flit_o), 32'h0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      random_inputs();
      settle_check("rand_post");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
